// File: rtl/mem_stage_ctrl_pkg.sv
// ============================================================================
// mem_stage_ctrl_pkg : EXE/MEM bundle field map, FSM states and op decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_stage_ctrl_pkg;

  localparam int BUNDLE_W = 52;
  localparam int OP_DW    = 16;
  localparam int RD_W     = 5;

  localparam int F_MEM_RD     = 51;
  localparam int F_MEM_WR     = 50;
  localparam int F_REG_WR     = 49;
  localparam int F_MEM_TO_REG = 48;
  localparam int F_RD_HI      = 47;
  localparam int F_RD_LO      = 43;
  localparam int F_RSV_HI     = 42;
  localparam int F_RSV_LO     = 32;
  localparam int F_ALU_HI     = 31;
  localparam int F_ALU_LO     = 16;
  localparam int F_WD_HI      = 15;
  localparam int F_WD_LO      = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_wr;
    logic             mem_to_reg;
    logic [RD_W-1:0]  rd;
    logic [OP_DW-1:0] alu;
    logic [OP_DW-1:0] wdata;
  } op_t;

  function automatic op_t decode_op(input logic [BUNDLE_W-1:0] b);
    op_t o;
    o.mem_rd     = b[F_MEM_RD];
    o.mem_wr     = b[F_MEM_WR];
    o.reg_wr     = b[F_REG_WR];
    o.mem_to_reg = b[F_MEM_TO_REG];
    o.rd         = b[F_RD_HI:F_RD_LO];
    o.alu        = b[F_ALU_HI:F_ALU_LO];
    o.wdata      = b[F_WD_HI:F_WD_LO];
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_ctrl_if.sv
// ============================================================================
// mem_stage_ctrl_if : EXE/MEM bundle, data-memory bus and MEM/WB result
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_stage_ctrl_if #(
  parameter int N      = 51,
  parameter int DATA_W = 16
);
  logic [N:0]        c;
  logic              stall;
  logic              bus_req;
  logic              bus_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              wb_valid;
  logic              wb_reg_wr;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              bus_err;

  // slave = the memory stage, master = everything around it
  modport slave (
    input  c, bus_gnt, mem_rdata, mem_ack,
    output stall, bus_req, mem_en, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_reg_wr, wb_rd, wb_data, bus_err
  );

  modport master (
    output c, bus_gnt, mem_rdata, mem_ack,
    input  stall, bus_req, mem_en, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_reg_wr, wb_rd, wb_data, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// mem_timeout_ctr : cycle counter with clear/enable, terminal count at TIMEOUT-1
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !tc_o)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// mem_stage_ctrl : EXE/MEM consumer running loads/stores on the arbitrated bus
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int N       = 51,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_ctrl_if.slave bus
);
  logic [N:0] w_bundle;
  op_t        w_op;
  logic       unused_rsvd;
  logic       w_tc;

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  logic              stall_q, stall_d;
  logic              bus_req_q, bus_req_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_wr_q, wb_reg_wr_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              bus_err_q, bus_err_d;

  assign w_bundle    = bus.c;
  assign w_op        = decode_op(w_bundle);
  assign unused_rsvd = ^w_bundle[F_RSV_HI:F_RSV_LO];

  // Counter runs only while in ACCESS; any exit (including a gnt-loss retry) restarts it
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != S_ACCESS),
    .en_i  (state_q == S_ACCESS),
    .tc_o  (w_tc)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wb_valid_d  = 1'b0;
    wb_reg_wr_d = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    bus_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_op.mem_rd && w_op.mem_wr) begin
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_rd_d    = w_op.rd;
          wb_data_d  = w_op.alu;
        end else if (w_op.mem_rd || w_op.mem_wr) begin
          op_d    = w_op;
          state_d = S_REQ;
        end else if (w_op.reg_wr || w_op.mem_to_reg) begin
          wb_valid_d  = 1'b1;
          wb_reg_wr_d = w_op.reg_wr;
          wb_rd_d     = w_op.rd;
          wb_data_d   = w_op.alu;
        end
      end
      S_REQ: begin
        if (bus.bus_gnt)
          state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.mem_ack) begin
          state_d     = S_IDLE;
          wb_valid_d  = 1'b1;
          wb_reg_wr_d = op_q.mem_rd && op_q.reg_wr;
          wb_rd_d     = op_q.rd;
          wb_data_d   = (op_q.mem_rd && op_q.mem_to_reg) ? bus.mem_rdata : op_q.alu;
        end else if (!bus.bus_gnt) begin
          state_d = S_REQ;
        end else if (w_tc) begin
          state_d    = S_IDLE;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_rd_d    = op_q.rd;
        end
      end
      default: state_d = S_IDLE;
    endcase

    stall_d   = (state_d != S_IDLE);
    bus_req_d = (state_d != S_IDLE);
    mem_en_d  = (state_d == S_ACCESS);
    mem_we_d  = mem_en_d && op_d.mem_wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      stall_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_reg_wr_q <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      stall_q     <= stall_d;
      bus_req_q   <= bus_req_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      wb_valid_q  <= wb_valid_d;
      wb_reg_wr_q <= wb_reg_wr_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.stall     = stall_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = op_q.alu;
  assign bus.mem_wdata = op_q.wdata;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_reg_wr = wb_reg_wr_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.bus_err   = bus_err_q;
endmodule

`default_nettype wire
